// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: next-PC select codes, special instruction
// words, reset PC and the fetch-stage state encoding.
package mips_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_JR     = 2'b11
  } pc_src_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD        = 32'hFFFF_FFFF;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/ID/debug controls in, fetch address and IF/ID contents out.
interface if_stage_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  logic               i_enable;
  logic               i_stall;
  logic               i_flush;
  logic [1:0]         i_pc_src;
  logic [PC_W-1:0]    i_branch_target;
  logic [PC_W-1:0]    i_jump_target;
  logic [PC_W-1:0]    i_jr_target;
  logic [INSTR_W-1:0] i_instr;
  logic [PC_W-1:0]    o_pc;
  logic [INSTR_W-1:0] o_if_id_instr;
  logic [PC_W-1:0]    o_if_id_pc4;
  logic               o_if_id_valid;
  logic               o_halted;
  logic [31:0]        o_fetch_count;

  modport master (
    output i_enable, i_stall, i_flush, i_pc_src,
           i_branch_target, i_jump_target, i_jr_target, i_instr,
    input  o_pc, o_if_id_instr, o_if_id_pc4, o_if_id_valid, o_halted, o_fetch_count
  );

  modport slave (
    input  i_enable, i_stall, i_flush, i_pc_src,
           i_branch_target, i_jump_target, i_jr_target, i_instr,
    output o_pc, o_if_id_instr, o_if_id_pc4, o_if_id_valid, o_halted, o_fetch_count
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Hold wins over bubble so a stall keeps the
// instruction waiting in ID even when a flush arrives alongside it.
module if_id_reg #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               hold,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [PC_W-1:0]    d_pc4,
  output logic [INSTR_W-1:0] q_instr,
  output logic [PC_W-1:0]    q_pc4,
  output logic               q_valid
);
  logic [INSTR_W-1:0] instr_reg;
  logic [PC_W-1:0]    pc4_reg;
  logic               valid_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      instr_reg <= '0;
      pc4_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (!hold) begin
      if (bubble) begin
        instr_reg <= INSTR_W'(mips_pkg::NOP_WORD);
        pc4_reg   <= '0;
        valid_reg <= 1'b0;
      end else begin
        instr_reg <= d_instr;
        pc4_reg   <= d_pc4;
        valid_reg <= 1'b1;
      end
    end
  end

  assign q_instr = instr_reg;
  assign q_pc4   = pc4_reg;
  assign q_valid = valid_reg;
endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, next-PC mux, RUN/HALTED FSM, fetch counter,
// and the IF/ID register feeding decode.
module if_stage
  import mips_pkg::pc_src_t, mips_pkg::fetch_state_t,
         mips_pkg::PC_SEQ, mips_pkg::PC_BRANCH, mips_pkg::PC_JUMP, mips_pkg::PC_JR,
         mips_pkg::ST_RUN, mips_pkg::ST_HALTED;
#(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [PC_W-1:0]    RESET_PC  = PC_W'(mips_pkg::RESET_PC_DEFAULT),
  parameter logic [INSTR_W-1:0] HALT_WORD = INSTR_W'(mips_pkg::HALT_WORD)
) (
  input logic       i_clk,
  input logic       i_rst_n,
  if_stage_if.slave bus
);
  fetch_state_t    state_reg;
  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] pc4;
  logic [PC_W-1:0] pc_next;
  logic [31:0]     count_reg;
  logic            halted_reg;
  logic            halt_hit;
  logic            ifid_hold;
  logic            ifid_bubble;

  assign pc4      = pc_reg + PC_W'(4);
  assign halt_hit = (bus.i_instr == HALT_WORD);

  always_comb begin
    pc_next = pc4;
    case (pc_src_t'(bus.i_pc_src))
      PC_SEQ:    pc_next = pc4;
      PC_BRANCH: pc_next = bus.i_branch_target;
      PC_JUMP:   pc_next = bus.i_jump_target;
      PC_JR:     pc_next = bus.i_jr_target;
      default:   pc_next = pc4;
    endcase
  end

  // Stall is only meaningful while running; once halted, IF/ID keeps loading bubbles.
  assign ifid_hold   = !bus.i_enable || (state_reg == ST_RUN && bus.i_stall);
  assign ifid_bubble = (state_reg == ST_HALTED) || bus.i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= ST_RUN;
      pc_reg     <= RESET_PC;
      count_reg  <= '0;
      halted_reg <= 1'b0;
    end else if (bus.i_enable) begin
      case (state_reg)
        ST_RUN: begin
          if (!bus.i_stall) begin
            if (bus.i_flush) begin
              pc_reg <= pc_next;
            end else begin
              count_reg <= count_reg + 32'd1;
              // A HALT parks the PC on itself so the debug unit sees where fetch stopped.
              if (halt_hit) begin
                state_reg  <= ST_HALTED;
                halted_reg <= 1'b1;
              end else begin
                pc_reg <= pc_next;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .hold    (ifid_hold),
    .bubble  (ifid_bubble),
    .d_instr (bus.i_instr),
    .d_pc4   (pc4),
    .q_instr (bus.o_if_id_instr),
    .q_pc4   (bus.o_if_id_pc4),
    .q_valid (bus.o_if_id_valid)
  );

  assign bus.o_pc          = pc_reg;
  assign bus.o_halted      = halted_reg;
  assign bus.o_fetch_count = count_reg;
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, stall, redirects,
// PC wrap, HALT behaviour, enable gating and reset while halted.
module tb_if_stage;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  if_stage_if #(.PC_W(32), .INSTR_W(32)) bus ();

  if_stage dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One enabled/disabled edge, then sample 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] pc4, input logic valid, input logic halted,
                         input logic [31:0] cnt);
    chk({tag, ".pc"},     bus.o_pc, pc);
    chk({tag, ".instr"},  bus.o_if_id_instr, instr);
    chk({tag, ".pc4"},    bus.o_if_id_pc4, pc4);
    chk({tag, ".valid"},  {31'd0, bus.o_if_id_valid}, {31'd0, valid});
    chk({tag, ".halted"}, {31'd0, bus.o_halted}, {31'd0, halted});
    chk({tag, ".count"},  bus.o_fetch_count, cnt);
    $display("step %-10s pc=%h ifid_instr=%h pc4=%h valid=%0b halted=%0b count=%0d",
             tag, bus.o_pc, bus.o_if_id_instr, bus.o_if_id_pc4, bus.o_if_id_valid,
             bus.o_halted, bus.o_fetch_count);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n               = 1'b0;
    bus.i_enable        = 1'b1;
    bus.i_stall         = 1'b0;
    bus.i_flush         = 1'b0;
    bus.i_pc_src        = 2'b00;
    bus.i_branch_target = 32'h0000_0100;
    bus.i_jump_target   = 32'h0000_0200;
    bus.i_jr_target     = 32'h0000_0300;
    bus.i_instr         = 32'h2001_0001;
    #1;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch from RESET_PC
    step();
    chk_all("seq1", 32'h4, 32'h2001_0001, 32'h4, 1'b1, 1'b0, 32'd1);
    bus.i_instr = 32'h2002_0002;
    step();
    chk_all("seq2", 32'h8, 32'h2002_0002, 32'h8, 1'b1, 1'b0, 32'd2);

    // Stall at PC=8 swallows a simultaneous flush+branch
    bus.i_stall = 1'b1; bus.i_flush = 1'b1; bus.i_pc_src = 2'b01;
    bus.i_instr = 32'h2003_0003;
    step();
    chk_all("stall", 32'h8, 32'h2002_0002, 32'h8, 1'b1, 1'b0, 32'd2);
    bus.i_stall = 1'b0; bus.i_flush = 1'b0; bus.i_pc_src = 2'b00;

    step();
    chk_all("seq3", 32'hC, 32'h2003_0003, 32'hC, 1'b1, 1'b0, 32'd3);
    bus.i_instr = 32'h2004_0004;
    step();
    chk_all("seq4", 32'h10, 32'h2004_0004, 32'h10, 1'b1, 1'b0, 32'd4);

    // Enable low while running: jump select and new instr must not take effect
    bus.i_enable = 1'b0; bus.i_pc_src = 2'b10; bus.i_jump_target = 32'h80;
    bus.i_instr = 32'h2005_0005;
    for (int i = 0; i < 3; i++) step();
    chk_all("dis_run", 32'h10, 32'h2004_0004, 32'h10, 1'b1, 1'b0, 32'd4);
    bus.i_enable = 1'b1;

    // Branch redirect with flush at PC=0x10
    bus.i_flush = 1'b1; bus.i_pc_src = 2'b01; bus.i_branch_target = 32'h40;
    step();
    chk_all("branch", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 32'd4);

    // JR to top of address space, then sequential wrap
    bus.i_pc_src = 2'b11; bus.i_jr_target = 32'hFFFF_FFFC;
    step();
    chk_all("jr", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 32'd4);
    bus.i_flush = 1'b0; bus.i_pc_src = 2'b00; bus.i_instr = 32'h2006_0006;
    step();
    chk_all("wrap", 32'h0, 32'h2006_0006, 32'h0, 1'b1, 1'b0, 32'd5);

    // Jump to 0x20 while a flushed HALT_WORD is discarded
    bus.i_flush = 1'b1; bus.i_pc_src = 2'b10; bus.i_jump_target = 32'h20;
    bus.i_instr = 32'hFFFF_FFFF;
    step();
    chk_all("halt_fl", 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 32'd5);

    // HALT accepted at PC=0x20
    bus.i_flush = 1'b0; bus.i_pc_src = 2'b00;
    step();
    chk_all("halt", 32'h20, 32'hFFFF_FFFF, 32'h24, 1'b1, 1'b1, 32'd6);

    // Halted: flush/branch ignored, IF/ID fills with bubbles
    bus.i_flush = 1'b1; bus.i_pc_src = 2'b01; bus.i_branch_target = 32'h40;
    bus.i_instr = 32'h1234_5678;
    step();
    chk_all("halted1", 32'h20, 32'h0, 32'h0, 1'b0, 1'b1, 32'd6);
    bus.i_flush = 1'b0; bus.i_stall = 1'b1; bus.i_pc_src = 2'b00;
    step();
    chk_all("halted2", 32'h20, 32'h0, 32'h0, 1'b0, 1'b1, 32'd6);
    bus.i_stall = 1'b0;

    // Enable low while halted
    bus.i_enable = 1'b0; bus.i_pc_src = 2'b10; bus.i_jump_target = 32'h80;
    for (int i = 0; i < 3; i++) step();
    chk_all("dis_halt", 32'h20, 32'h0, 32'h0, 1'b0, 1'b1, 32'd6);
    bus.i_enable = 1'b1;

    // Asynchronous reset mid-cycle while halted
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rst_halt", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_pc_src = 2'b00; bus.i_instr = 32'h2007_0007;
    step();
    chk_all("post_rst", 32'h4, 32'h2007_0007, 32'h4, 1'b1, 1'b0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
